// File: rtl/mem_access_stage_if.sv
// Bundles the EX/MEM entry, the data bus and the WB result of the MEM stage.
// slave = the stage itself, master = whatever drives the stage (upstream, bus, bench).
interface mem_access_stage_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned BE_W  = 4;

    // EX/MEM entry
    logic             in_valid;
    logic             in_ready;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_size;
    logic             mem_unsigned;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  data_2;
    logic [REG_W-1:0] rd_in;
    logic             reg_write_in;

    // data bus
    logic             bus_req;
    logic             bus_we;
    logic [XLEN-1:0]  bus_addr;
    logic [BE_W-1:0]  bus_be;
    logic [XLEN-1:0]  bus_wdata;
    logic             bus_ack;
    logic [XLEN-1:0]  bus_rdata;

    // WB result
    logic             out_valid;
    logic [XLEN-1:0]  wb_data;
    logic [REG_W-1:0] wb_rd;
    logic             wb_reg_write;
    logic             addr_err;
    logic             bus_err;

    modport slave (
        input  in_valid, mem_read, mem_write, mem_size, mem_unsigned,
               res, data_2, rd_in, reg_write_in, bus_ack, bus_rdata,
        output in_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               out_valid, wb_data, wb_rd, wb_reg_write, addr_err, bus_err
    );

    modport master (
        output in_valid, mem_read, mem_write, mem_size, mem_unsigned,
               res, data_2, rd_in, reg_write_in, bus_ack, bus_rdata,
        input  in_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               out_valid, wb_data, wb_rd, wb_reg_write, addr_err, bus_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte/half/word loads and stores over a req/ack bus, one WB result per entry.
module mem_access_stage #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  m
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // bus side
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [XLEN-1:0]    bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [XLEN-1:0]    bus_wdata_q, bus_wdata_d;

    // instruction context held across the access
    logic               ld_q, ld_d;
    logic               uns_q, uns_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               rw_q, rw_d;

    // WB side
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
    logic               wb_rw_q, wb_rw_d;
    logic               addr_err_q, addr_err_d;
    logic               bus_err_q, bus_err_d;

    logic               mem_op_c;
    logic               bad_c;
    logic [XLEN-1:0]    lane_c;
    logic [XLEN-1:0]    load_val_c;

    // Classify the incoming entry: is it a memory op, and is it illegal.
    always_comb begin
        mem_op_c = m.mem_read | m.mem_write;
        bad_c    = (m.mem_read & m.mem_write)
                 | (m.mem_size == 2'b11)
                 | ((m.mem_size == 2'b01) & m.res[0])
                 | ((m.mem_size == 2'b10) & (m.res[1:0] != 2'b00));
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        lane_c     = m.bus_rdata >> {off_q, 3'b000};
        load_val_c = lane_c;
        case (size_q)
            2'b00:   load_val_c = {{24{~uns_q & lane_c[7]}},  lane_c[7:0]};
            2'b01:   load_val_c = {{16{~uns_q & lane_c[15]}}, lane_c[15:0]};
            default: load_val_c = lane_c;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/ACCESS sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_d        = ld_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        res_d       = res_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        out_valid_d = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m.in_valid) begin
                    if (!mem_op_c) begin
                        out_valid_d = 1'b1;
                        wb_data_d   = m.res;
                        wb_rd_d     = m.rd_in;
                        wb_rw_d     = m.reg_write_in;
                    end else if (bad_c) begin
                        out_valid_d = 1'b1;
                        addr_err_d  = 1'b1;
                        wb_data_d   = m.res;
                        wb_rd_d     = m.rd_in;
                        wb_rw_d     = 1'b0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = m.mem_write;
                        bus_addr_d  = {m.res[XLEN-1:2], 2'b00};
                        ld_d        = m.mem_read;
                        uns_d       = m.mem_unsigned;
                        size_d      = m.mem_size;
                        off_d       = m.res[1:0];
                        res_d       = m.res;
                        rd_d        = m.rd_in;
                        rw_d        = m.reg_write_in;
                        case (m.mem_size)
                            2'b00: begin
                                bus_be_d    = 4'b0001 << m.res[1:0];
                                bus_wdata_d = {4{m.data_2[7:0]}};
                            end
                            2'b01: begin
                                bus_be_d    = 4'b0011 << m.res[1:0];
                                bus_wdata_d = {2{m.data_2[15:0]}};
                            end
                            default: begin
                                bus_be_d    = 4'b1111;
                                bus_wdata_d = m.data_2;
                            end
                        endcase
                    end
                end
            end

            ST_ACCESS: begin
                if (m.bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    wb_rd_d     = rd_q;
                    if (ld_q) begin
                        wb_data_d = load_val_c;
                        wb_rw_d   = rw_q;
                    end else begin
                        wb_data_d = res_q;
                        wb_rw_d   = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    wb_data_d   = res_q;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State register; reset discards any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            ld_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            res_q       <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            out_valid_q <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_q        <= ld_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            off_q       <= off_d;
            res_q       <= res_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            out_valid_q <= out_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Ready is a decode of the state flop, masked while reset is held.
    assign m.in_ready     = (state_q == ST_IDLE) & ~rst;
    assign m.bus_req      = bus_req_q;
    assign m.bus_we       = bus_we_q;
    assign m.bus_addr     = bus_addr_q;
    assign m.bus_be       = bus_be_q;
    assign m.bus_wdata    = bus_wdata_q;
    assign m.out_valid    = out_valid_q;
    assign m.wb_data      = wb_data_q;
    assign m.wb_rd        = wb_rd_q;
    assign m.wb_reg_write = wb_rw_q;
    assign m.addr_err     = addr_err_q;
    assign m.bus_err      = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, randomized ops vs. model, corner sequences.
module tb_mem_access_stage;
    localparam int unsigned WAIT_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_stage_if m ();

    mem_access_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        bit [1:0]    size;
        bit          uns;
        bit [31:0]   res;
        bit [31:0]   d2;
        bit [31:0]   rdata;
        bit [4:0]    rd_in;
        bit          rw_in;
    } op_t;

    typedef struct {
        bit          req;
        bit          we;
        bit [31:0]   addr;
        bit [3:0]    be;
        bit [31:0]   wdata;
        bit [31:0]   wb_data;
        bit [4:0]    wb_rd;
        bit          wb_rw;
        bit          aerr;
        bit          berr;
    } exp_t;

    typedef struct {
        op_t  op;
        int   ack_dly;
        exp_t ex;
    } vec_t;

    function automatic op_t mk_op(bit rd, bit wr, bit [1:0] size, bit uns, bit [31:0] res,
                                  bit [31:0] d2, bit [31:0] rdata, bit [4:0] rd_in, bit rw_in);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.res = res;
        o.d2 = d2; o.rdata = rdata; o.rd_in = rd_in; o.rw_in = rw_in;
        return o;
    endfunction

    function automatic exp_t mk_ex(bit req, bit we, bit [31:0] addr, bit [3:0] be, bit [31:0] wdata,
                                   bit [31:0] wb_data, bit [4:0] wb_rd, bit wb_rw, bit aerr);
        exp_t e;
        e.req = req; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        e.wb_data = wb_data; e.wb_rd = wb_rd; e.wb_rw = wb_rw; e.aerr = aerr; e.berr = 1'b0;
        return e;
    endfunction

    // Reference behaviour from the architectural rules, using plain arithmetic.
    function automatic exp_t model(op_t o);
        exp_t        e;
        int unsigned off    = o.res % 4;
        int unsigned nbytes = 1 << o.size;
        longint      v;
        bit          bad;
        e = mk_ex(0, 0, 0, 0, 0, o.res, o.rd_in, o.rw_in, 0);
        bad = (o.rd && o.wr) || (o.size == 3) || (o.size == 1 && off % 2 != 0) || (o.size == 2 && off != 0);
        if (!o.rd && !o.wr) return e;
        if (bad) begin
            e.aerr  = 1'b1;
            e.wb_rw = 1'b0;
            return e;
        end
        e.req  = 1'b1;
        e.we   = o.wr;
        e.addr = o.res - off;
        e.be   = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      e.wdata = (o.d2 % 256) * 32'h0101_0101;
        else if (nbytes == 2) e.wdata = (o.d2 % 65536) * 32'h0001_0001;
        else                  e.wdata = o.d2;
        if (o.rd) begin
            v = longint'(o.rdata / (32'd1 << (8 * off)));
            if (nbytes < 4) begin
                v = v % (64'd1 << (8 * nbytes));
                if (!o.uns && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
            end
            e.wb_data = 32'(v);
        end else begin
            e.wb_rw = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input op_t o);
        m.mem_read     = o.rd;
        m.mem_write    = o.wr;
        m.mem_size     = o.size;
        m.mem_unsigned = o.uns;
        m.res          = o.res;
        m.data_2       = o.d2;
        m.rd_in        = o.rd_in;
        m.reg_write_in = o.rw_in;
    endtask

    // Issue one entry, act as the bus (ack after ack_dly request cycles, -1 = never), check WB result.
    task automatic run_op(input string nm, input op_t o, input int ack_dly, input exp_t ex);
        int cyc  = 0;
        int nreq = 0;
        bit got  = 0;
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(m.in_ready), 32'd1);
        drive_op(o);
        m.bus_rdata = o.rdata;
        m.in_valid  = 1'b1;
        @(negedge clk);
        m.in_valid = 1'b0;
        while (!got && cyc < int'(WAIT_MAX) + 8) begin
            m.bus_ack = 1'b0;
            if (m.out_valid) begin
                got = 1;
            end else begin
                if (m.bus_req) begin
                    chk({nm, " bus_we"},   32'(m.bus_we),   32'(ex.we));
                    chk({nm, " bus_addr"}, m.bus_addr,      ex.addr);
                    chk({nm, " bus_be"},   32'(m.bus_be),   32'(ex.be));
                    if (ex.we) chk({nm, " bus_wdata"}, m.bus_wdata, ex.wdata);
                    chk({nm, " in_ready busy"}, 32'(m.in_ready), 32'd0);
                    if (nreq == ack_dly) m.bus_ack = 1'b1;
                    nreq++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        m.bus_ack = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s no_out_valid: got none within %0d cycles, required one", nm, cyc);
            return;
        end
        lat = !ex.req ? 0 : (ack_dly < 0 ? int'(WAIT_MAX) : ack_dly + 1);
        chk({nm, " latency"},  32'(cyc),  32'(lat));
        chk({nm, " req_cycles"}, 32'(nreq), 32'(lat));
        chk({nm, " wb_reg_write"}, 32'(m.wb_reg_write), 32'(ex.wb_rw));
        chk({nm, " addr_err"}, 32'(m.addr_err), 32'(ex.aerr));
        chk({nm, " bus_err"},  32'(m.bus_err),  32'(ex.berr));
        if (!ex.aerr && !ex.berr) begin
            chk({nm, " wb_data"}, m.wb_data, ex.wb_data);
            chk({nm, " wb_rd"},   32'(m.wb_rd), 32'(ex.wb_rd));
        end
        @(negedge clk);
        chk({nm, " out_valid pulse"}, 32'(m.out_valid), 32'd0);
        chk({nm, " bus_req idle"},    32'(m.bus_req),   32'd0);
        if (!ex.aerr && !ex.berr) chk({nm, " wb_data hold"}, m.wb_data, ex.wb_data);
    endtask

    vec_t vecs[12];

    initial begin
        op_t  o;
        exp_t e;

        //                 rd wr sz uns res           d2            rdata         rd rw
        vecs[0]  = '{mk_op(0, 0, 2, 0, 32'h10,       32'h0,        32'h0,        8, 1), 0,
                     mk_ex(0, 0, 32'h0,   4'b0000, 32'h0,        32'h10,       8, 1, 0)};
        vecs[1]  = '{mk_op(1, 0, 0, 0, 32'h103,      32'h0,        32'h8000_0000, 3, 1), 0,
                     mk_ex(1, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFF_FF80, 3, 1, 0)};
        vecs[2]  = '{mk_op(1, 0, 0, 1, 32'h103,      32'h0,        32'h8000_0000, 3, 1), 0,
                     mk_ex(1, 0, 32'h100, 4'b1000, 32'h0,        32'h0000_0080, 3, 1, 0)};
        vecs[3]  = '{mk_op(0, 1, 1, 0, 32'h202,      32'h1234_ABCD, 32'h0,       4, 1), 0,
                     mk_ex(1, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h202,      4, 0, 0)};
        vecs[4]  = '{mk_op(1, 0, 2, 0, 32'h101,      32'h0,        32'h0,        9, 1), 0,
                     mk_ex(0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        9, 0, 1)};
        vecs[5]  = '{mk_op(1, 0, 1, 0, 32'h103,      32'h0,        32'h0,        9, 1), 0,
                     mk_ex(0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        9, 0, 1)};
        vecs[6]  = '{mk_op(1, 0, 2, 0, 32'h200,      32'h0,        32'hDEAD_BEEF, 7, 1), 3,
                     mk_ex(1, 0, 32'h200, 4'b1111, 32'h0,        32'hDEAD_BEEF, 7, 1, 0)};
        vecs[7]  = '{mk_op(1, 0, 1, 0, 32'h102,      32'h0,        32'h8001_1234, 2, 1), 1,
                     mk_ex(1, 0, 32'h100, 4'b1100, 32'h0,        32'hFFFF_8001, 2, 1, 0)};
        vecs[8]  = '{mk_op(1, 0, 1, 1, 32'h102,      32'h0,        32'h8001_1234, 2, 1), 0,
                     mk_ex(1, 0, 32'h100, 4'b1100, 32'h0,        32'h0000_8001, 2, 1, 0)};
        vecs[9]  = '{mk_op(1, 0, 3, 0, 32'h100,      32'h0,        32'h0,        1, 1), 0,
                     mk_ex(0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0, 1)};
        vecs[10] = '{mk_op(1, 1, 2, 0, 32'h100,      32'h0,        32'h0,        1, 1), 0,
                     mk_ex(0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0, 1)};
        vecs[11] = '{mk_op(0, 1, 0, 0, 32'h5,        32'h0000_00AB, 32'h0,       6, 1), 2,
                     mk_ex(1, 1, 32'h4,   4'b0010, 32'hABAB_ABAB, 32'h5,        6, 0, 0)};

        m.in_valid = 1'b0;
        m.bus_ack  = 1'b0;
        m.bus_rdata = '0;
        drive_op(mk_op(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(m.out_valid), 32'd0);
        chk("reset bus_req",   32'(m.bus_req),   32'd0);
        chk("reset in_ready",  32'(m.in_ready),  32'd0);
        chk("reset wb_reg_write", 32'(m.wb_reg_write), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(m.in_ready), 32'd1);

        // directed table
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].ack_dly, vecs[i].ex);

        // bus timeout on a load that is never acked
        o = mk_op(1, 0, 2, 0, 32'h400, 32'h0, 32'h0, 10, 1);
        e = model(o);
        e.berr  = 1'b1;
        e.wb_rw = 1'b0;
        run_op("timeout", o, -1, e);

        // randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 9);
            o.rd    = (kind >= 2 && kind <= 5) || kind == 9;
            o.wr    = (kind >= 6);
            o.size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            o.uns   = 1'($urandom_range(0, 1));
            o.res   = $urandom;
            o.d2    = $urandom;
            o.rdata = $urandom;
            o.rd_in = 5'($urandom_range(0, 31));
            o.rw_in = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), o, $urandom_range(0, 4), model(o));
        end

        // back-to-back, with an entry held upstream during ACCESS
        @(negedge clk);
        drive_op(mk_op(1, 0, 2, 0, 32'h40, 32'h0, 32'h0, 5, 1));
        m.in_valid = 1'b1;
        @(negedge clk);
        chk("b2b busy req",      32'(m.bus_req),  32'd1);
        chk("b2b busy in_ready", 32'(m.in_ready), 32'd0);
        drive_op(mk_op(0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 6, 1));
        @(negedge clk);
        chk("b2b held no out", 32'(m.out_valid), 32'd0);
        m.bus_ack   = 1'b1;
        m.bus_rdata = 32'h1122_3344;
        @(negedge clk);
        m.bus_ack = 1'b0;
        chk("b2b load out_valid", 32'(m.out_valid), 32'd1);
        chk("b2b load wb_data",   m.wb_data,        32'h1122_3344);
        chk("b2b load wb_rd",     32'(m.wb_rd),     32'd5);
        chk("b2b in_ready",       32'(m.in_ready),  32'd1);
        @(negedge clk);
        m.in_valid = 1'b0;
        chk("b2b alu out_valid", 32'(m.out_valid), 32'd1);
        chk("b2b alu wb_data",   m.wb_data,        32'h77);
        chk("b2b alu wb_rd",     32'(m.wb_rd),     32'd6);
        @(negedge clk);
        chk("b2b single pulse", 32'(m.out_valid), 32'd0);

        // stray ack while idle
        m.bus_ack = 1'b1;
        @(negedge clk);
        m.bus_ack = 1'b0;
        chk("stray ack out_valid", 32'(m.out_valid), 32'd0);
        chk("stray ack bus_req",   32'(m.bus_req),   32'd0);

        // reset two cycles into a held load
        drive_op(mk_op(1, 0, 2, 0, 32'h300, 32'h0, 32'h0, 11, 1));
        m.in_valid = 1'b1;
        @(negedge clk);
        m.in_valid = 1'b0;
        chk("rst-mid req1", 32'(m.bus_req), 32'd1);
        @(negedge clk);
        chk("rst-mid req2", 32'(m.bus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid bus_req",   32'(m.bus_req),   32'd0);
        chk("rst-mid out_valid", 32'(m.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst-mid after out_valid", 32'(m.out_valid), 32'd0);
        chk("rst-mid after in_ready",  32'(m.in_ready),  32'd1);
        run_op("after-rst", vecs[0].op, 0, vecs[0].ex);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
